// File: rtl/tz_pkg.sv
// ---------------------------------------------------------------------------
// tz_pkg : shared types for the trailing-zero count link
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package tz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    ONE  = 2'd2
  } tz_state_e;

  // Count width: must hold 0..width inclusive.
  function automatic int tz_cw(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trailing_zeroes_expander.sv
// ---------------------------------------------------------------------------
// trailing_zeroes_expander : turns trailing-zero counts back into an LSB-first
// bit stream. Optional macro TZ_EXPAND_RANGE_CHECK_EN adds the sticky err port.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module trailing_zeroes_expander
  import tz_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int CW         = tz_cw(DATA_WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last
`ifdef TZ_EXPAND_RANGE_CHECK_EN
  ,
  output logic          err
`endif
);

  localparam logic [CW-1:0] C_DW  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  tz_state_e     state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          full_q, full_d;
  logic          out_xfer;
  logic          in_xfer;
  logic          run_done;
  logic          load_ok;
  logic [CW-1:0] n_eff;

`ifdef TZ_EXPAND_RANGE_CHECK_EN
  logic          err_q, err_d;
  assign err = err_q;
`endif

  assign dout       = (state_q == ONE);
  assign dout_valid = (state_q != IDLE);
  assign dout_last  = (state_q == ONE) ||
                      ((state_q == ZERO) && (rem_q == '0) && full_q);
  assign out_xfer   = dout_valid && dout_ready;
  // Ready in the cycle the last bit leaves, so the next count loads without a bubble.
  assign din_ready  = (state_q == IDLE) || (out_xfer && dout_last);
  assign in_xfer    = din_valid && din_ready;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    full_d   = full_q;
    run_done = 1'b0;
    load_ok  = 1'b1;
    n_eff    = din;
`ifdef TZ_EXPAND_RANGE_CHECK_EN
    err_d    = err_q;
`endif

    case (state_q)
      ZERO: begin
        if (out_xfer) begin
          if (rem_q != '0) begin
            rem_d = rem_q - C_ONE;
          end else if (!full_q) begin
            state_d = ONE;
          end else begin
            run_done = 1'b1;
          end
        end
      end
      ONE: begin
        if (out_xfer) begin
          run_done = 1'b1;
        end
      end
      default: ;
    endcase

    if (run_done) begin
      state_d = IDLE;
      full_d  = 1'b0;
    end

    if (din > C_DW) begin
`ifdef TZ_EXPAND_RANGE_CHECK_EN
      load_ok = 1'b0;
      if (in_xfer) begin
        err_d = 1'b1;
      end
`else
      n_eff = C_DW;
`endif
    end

    if (in_xfer && load_ok) begin
      if (n_eff == '0) begin
        state_d = ONE;
        rem_d   = '0;
        full_d  = 1'b0;
      end else begin
        state_d = ZERO;
        rem_d   = n_eff - C_ONE;
        full_d  = (n_eff == C_DW);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      full_q  <= 1'b0;
`ifdef TZ_EXPAND_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      full_q  <= full_d;
`ifdef TZ_EXPAND_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

`default_nettype wire
